// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - mode/state encodings and the LED step function for the chaser.
package led_ctrl_pkg;

    localparam int LED_MAX = 32;

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_FILL   = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    localparam logic BDIR_LEFT  = 1'b0;
    localparam logic BDIR_RIGHT = 1'b1;

    // The reserved encoding 2'b11 behaves as SHIFT.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return MODE_BOUNCE;
            2'b10:   return MODE_FILL;
            default: return MODE_SHIFT;
        endcase
    endfunction

    // Computes on LED_MAX bits; only the low n bits are meaningful.
    function automatic logic [LED_MAX-1:0] next_pattern(
        input logic [LED_MAX-1:0] led,
        input int                 n,
        input mode_e              mode,
        input logic               dir,
        input logic               bdir
    );
        logic [LED_MAX-1:0] mask;
        logic [LED_MAX-1:0] msb;
        logic [LED_MAX-1:0] res;
        mask = '0;
        for (int i = 0; i < LED_MAX; i++) begin
            if (i < n) mask[i] = 1'b1;
        end
        msb = LED_MAX'(1) << (n - 1);
        case (mode)
            MODE_BOUNCE: res = (bdir == BDIR_LEFT) ? (led << 1) : (led >> 1);
            MODE_FILL: begin
                if (led == mask)  res = '0;
                else if (!dir)    res = (led << 1) | LED_MAX'(1);
                else              res = (led >> 1) | msb;
            end
            default: res = dir ? ((led >> 1) | (led << (n - 1)))
                               : ((led << 1) | (led >> (n - 1)));
        endcase
        return res & mask;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// rtl/led_prescaler.sv - step prescaler: counts 0..terminal-1 while enabled, pulses tick on wrap.
module led_prescaler #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] terminal,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // >= rather than == so a terminal that shrinks below the count still wraps.
    assign tick = en && (cnt_q >= (terminal - CNT_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_chaser_ctrl.sv
// rtl/led_chaser_ctrl.sv - LED chaser sequencer: STOP/RUN/HOLD FSM, pattern register, prescaler.
// Optional LED_SPEED_EN adds a speed input that divides the step terminal count.
module led_chaser_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int N_LEDS  = 4,
    parameter int DIV_MAX = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              hold,
    input  logic              dir,
    input  logic [1:0]        mode,
`ifdef LED_SPEED_EN
    input  logic [1:0]        speed,
`endif
    output logic [N_LEDS-1:0] led,
    output logic              tick,
    output logic              busy
);

    localparam int CNT_W = $clog2(DIV_MAX + 1);

    state_e              state_q, state_d;
    logic [N_LEDS-1:0]   led_q, led_d;
    mode_e               mode_q, mode_d;
    logic                bdir_q, bdir_d;
    logic                clr;
    logic                en;
    logic [CNT_W-1:0]    terminal;

`ifdef LED_SPEED_EN
    function automatic logic [CNT_W-1:0] speed_term(input logic [1:0] s);
        logic [CNT_W-1:0] t;
        t = CNT_W'(DIV_MAX) >> s;
        return (t == '0) ? CNT_W'(1) : t;
    endfunction

    logic [CNT_W-1:0] term_q;

    // Speed is picked up on every wrap; start and reset also load it so the first period is right.
    always_ff @(posedge clk) begin
        if (rst || start || tick) term_q <= speed_term(speed);
    end

    assign terminal = term_q;
`else
    assign terminal = CNT_W'(DIV_MAX);
`endif

    assign clr = start | stop;
    assign en  = (state_q == ST_RUN) & ~hold & ~clr;

    led_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .en       (en),
        .terminal (terminal),
        .tick     (tick)
    );

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        mode_d  = mode_q;
        bdir_d  = bdir_q;
        if (stop) begin
            state_d = ST_STOP;
            led_d   = '0;
        end else if (start) begin
            state_d = ST_RUN;
            led_d   = N_LEDS'(1);
            mode_d  = decode_mode(mode);
            bdir_d  = BDIR_LEFT;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hold) begin
                        state_d = ST_HOLD;
                    end else if (tick) begin
                        // A mode change spends its tick on a reload instead of a step.
                        if (decode_mode(mode) != mode_q) begin
                            mode_d = decode_mode(mode);
                            led_d  = N_LEDS'(1);
                            bdir_d = BDIR_LEFT;
                        end else begin
                            led_d = N_LEDS'(next_pattern(LED_MAX'(led_q), N_LEDS, mode_q, dir, bdir_q));
                            if (mode_q == MODE_BOUNCE) begin
                                if (led_d[N_LEDS-1]) bdir_d = BDIR_RIGHT;
                                else if (led_d[0])   bdir_d = BDIR_LEFT;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (!hold) state_d = ST_RUN;
                end
                default: state_d = ST_STOP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STOP;
            led_q   <= '0;
            mode_q  <= MODE_SHIFT;
            bdir_q  <= BDIR_LEFT;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            mode_q  <= mode_d;
            bdir_q  <= bdir_d;
        end
    end

    assign led  = led_q;
    assign busy = (state_q != ST_STOP);

endmodule
